// File: rtl/e_mdu_ctrl.sv
// ----------------------------------------------------------------------------
// e_mdu_ctrl
//
// Multiply/divide sequencer that sits beside the E-stage ALU of the 5-stage
// MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from E, keeps the
// unit busy for a fixed latency, and then commits the result to the
// architectural HI/LO registers. It also raises a D-stage stall request for
// any MDU-class instruction that would collide with an in-flight operation.
//
// Parameters
//   MULT_CYCLES : busy cycles for mult/multu (>= 1)
//   DIV_CYCLES  : busy cycles for div/divu   (>= 1)
//
// Ports
//   clk     : pipeline clock, rising edge
//   reset   : asynchronous reset, active low (0 = reset)
//   start   : E-stage instruction is an MDU write op this cycle
//   op      : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   A, B    : forwarded rs / rt data
//   D_is_md : D-stage instruction is an MDU-class instruction
//   cancel  : abort the in-flight op / suppress a start (MDU_CANCEL_EN only)
//   busy    : an operation is in flight
//   stall   : stall F/D and bubble D/E (combinational)
//   done    : one-cycle pulse in the cycle HI/LO commit
//   HI, LO  : architectural HI / LO
//
// Configuration macro
//   MDU_CANCEL_EN : when defined, 'cancel' aborts a busy operation without
//                   committing and suppresses a start presented in IDLE.
//                   When undefined, 'cancel' is ignored.
// ----------------------------------------------------------------------------
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_is_md,
    input  logic        cancel,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Counter is at least 4 bits and always wide enough for the longer latency.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    // A one-cycle latency has its done pulse in the very first busy cycle,
    // so done must already be raised by the start edge.
    localparam logic MULT_DONE_AT_START = (MULT_CYCLES == 1);
    localparam logic DIV_DONE_AT_START  = (DIV_CYCLES == 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      phi_q, phi_d;
    logic [31:0]      plo_q, plo_d;
    logic             pzero_q, pzero_d;
    logic             done_q, done_d;

    logic             cancel_eff;

`ifdef MDU_CANCEL_EN
    assign cancel_eff = cancel;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_eff    = 1'b0;
`endif

    // Arithmetic datapath. Operands are widened explicitly so the 64-bit
    // products are exact. A zero divisor is replaced by 1 only to keep the
    // dividers well defined; the result is discarded at commit in that case.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               b_zero;

    assign b_zero  = (B == 32'd0);
    assign divisor = b_zero ? 32'd1 : B;
    assign prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u  = {32'd0, A} * {32'd0, B};
    assign quot_s  = $signed(A) / $signed(divisor);
    assign rem_s   = $signed(A) % $signed(divisor);
    assign quot_u  = A / divisor;
    assign rem_u   = A % divisor;

    // State, counter, pending result and architectural HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            pzero_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pzero_q <= pzero_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. In IDLE a mult/div captures its result into the
    // pending registers and loads the latency counter; mthi/mtlo write HI/LO
    // directly. In BUSY the counter runs down and the pending result is
    // committed on the edge that leaves the cnt==1 cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pzero_d = pzero_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !cancel_eff) begin
                    case (op)
                        OP_MULT: begin
                            phi_d   = prod_s[63:32];
                            plo_d   = prod_s[31:0];
                            pzero_d = 1'b0;
                            cnt_d   = MULT_LOAD;
                            done_d  = MULT_DONE_AT_START;
                            state_d = S_BUSY;
                        end
                        OP_MULTU: begin
                            phi_d   = prod_u[63:32];
                            plo_d   = prod_u[31:0];
                            pzero_d = 1'b0;
                            cnt_d   = MULT_LOAD;
                            done_d  = MULT_DONE_AT_START;
                            state_d = S_BUSY;
                        end
                        OP_DIV: begin
                            phi_d   = rem_s;
                            plo_d   = quot_s;
                            pzero_d = b_zero;
                            cnt_d   = DIV_LOAD;
                            done_d  = DIV_DONE_AT_START;
                            state_d = S_BUSY;
                        end
                        OP_DIVU: begin
                            phi_d   = rem_u;
                            plo_d   = quot_u;
                            pzero_d = b_zero;
                            cnt_d   = DIV_LOAD;
                            done_d  = DIV_DONE_AT_START;
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end

            S_BUSY: begin
                if (cancel_eff) begin
                    // Flush: drop the pending result, no done pulse.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_TWO) begin
                        done_d = 1'b1;
                    end
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_IDLE;
                        // Division by zero leaves HI/LO untouched.
                        if (!pzero_q) begin
                            hi_d = phi_q;
                            lo_d = plo_q;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == S_BUSY);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

    // op[2]==0 selects the four mult/div codes that occupy the unit.
    assign stall = D_is_md & (busy | (start & ~op[2]));

endmodule

// File: doc/e_mdu_ctrl.md
# e_mdu_ctrl

Multiply/divide sequencer for the 5-stage MIPS pipeline; sits beside the E-stage ALU. It accepts mult/multu/div/divu/mthi/mtlo from E, holds the unit busy for a fixed latency, and commits results to the architectural HI/LO registers. It also drives the D-stage stall request for any MDU-class instruction that would collide with an in-flight operation. The stall feeds the existing stall controller (OR-ed into Stall).

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  E-stage instruction is an MDU write op this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved, ignored
- A  in  32  forwarded rs data (E_FWD_rs_data)
- B  in  32  forwarded rt data (E_FWD_rt_data)
- D_is_md  in  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- cancel  in  1  abort in-flight op (only with MDU_CANCEL_EN)
- busy  out  1  operation in flight
- stall  out  1  stall F/D, bubble D/E
- done  out  1  one-cycle pulse in the cycle HI/LO commit
- HI  out  32  architectural HI
- LO  out  32  architectural LO

## Operation
- States: IDLE, BUSY. Counter cnt (4 bits min, wide enough for max(MULT_CYCLES, DIV_CYCLES)).
- IDLE + start + op∈{0..3}: compute result into pending regs {pHI,pLO}; cnt←MULT_CYCLES or DIV_CYCLES; →BUSY.
- MULT: {pHI,pLO} = signed A×B (64b). MULTU: unsigned.
- DIV: pLO = A/B truncated toward zero, pHI = A%B with sign of A. DIVU: unsigned.
- B==0 on div/divu: full busy period, HI/LO left unchanged at commit, done still pulses.
- BUSY: cnt decrements each cycle; at cnt==1 edge: HI←pHI, LO←pLO, →IDLE.
- IDLE + start + MTHI: HI←A next edge; MTLO: LO←A next edge. No busy, no done.
- start while BUSY: ignored (stall guarantees it cannot occur legally).
- Reserved op codes: no state change.
- stall = D_is_md & (busy | (start & op∈{0..3})). Combinational.

## Timing
- Reset (reset=0, any time, including mid-operation): state IDLE, cnt 0, HI=0, LO=0, pHI=pLO=0, busy=0, done=0; pending op discarded.
- Mult issued in E at cycle 0: busy=1 cycles 1..MULT_CYCLES; done=1 in cycle MULT_CYCLES; new HI/LO visible cycle MULT_CYCLES+1. Div identical with DIV_CYCLES.
- busy, done, HI, LO registered; stall combinational from registered busy plus inputs.
- Back-to-back: an MDU op in D during cycle N (commit cycle) stalls; it enters E at N+1, earliest restart at N+1.
- mfhi/mflo in D while busy: stalled until busy=0; read HI/LO directly (already committed).
- mthi/mtlo result readable by mfhi/mflo one cycle later via normal E→HI path; no forwarding inside block.

## Configuration
- MDU_CANCEL_EN defined: cancel=1 while BUSY → next edge IDLE, busy=0, no done, HI/LO unchanged; cancel=1 with start in IDLE suppresses that start (including mthi/mtlo). Used for exception flush.
- Undefined: cancel port present but ignored; every started op runs to completion.

## Test plan
- Reset mid-op: issue DIV A=100 B=7, assert reset=0 in busy cycle 3 → busy=0, HI=0, LO=0 immediately; no done after release.
- MULT A=0xFFFFFFFF B=2 → busy 5 cycles, done in cycle 5, HI=0xFFFFFFFF LO=0xFFFFFFFE; MULTU same operands → HI=0x00000001 LO=0xFFFFFFFE.
- DIV A=-7 (0xFFFFFFF9) B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7 B=0 with HI=0x11 LO=0x22 preloaded → unchanged, done pulses at cycle 10.
- Stall: MULT in E, mflo in D → stall=1 cycles 0..5, 0 in cycle 6; mflo reads committed LO.
- MTHI A=0xDEADBEEF then MTLO A=0x12345678 consecutive → HI/LO updated next edges, busy never set; op=6 with start → no change.
- With MDU_CANCEL_EN: DIV, cancel=1 in busy cycle 4 → busy=0 next cycle, HI/LO unchanged, done never pulses; without macro same stimulus completes normally.
